// File: rtl/regfile_cmd_ctrl.sv
// regfile_cmd_ctrl: decodes write/read command frames from a serial byte
// stream, drives the RegFile port and returns read data as two bytes.
//   Write frame: AA addr data_lo data_hi    Read frame: BB addr
// Optional feature macro: CMD_TIMEOUT_EN -- aborts a frame whose inter-byte
// gap in a collect state reaches TIMEOUT_CYCLES.
module regfile_cmd_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  WrEn,
  output logic                  RdEn,
  input  logic [DATA_WIDTH-1:0] RdData,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_err
);

  localparam logic [7:0] HDR_WR    = 8'hAA;
  localparam logic [7:0] HDR_RD    = 8'hBB;
  // Address byte bits above the RegFile address range must be zero.
  localparam logic [7:0] ADDR_MASK = 8'hFF << ADDR_WIDTH;

  // Read data goes out as exactly two bytes; reject any other word width.
  if (DATA_WIDTH != 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("regfile_cmd_ctrl: DATA_WIDTH must be 16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DLO, WR_DHI, WR_EXEC,
    RD_ADDR, RD_EXEC, RD_WAIT, TX_LO, TX_HI
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              dlo_q;
  logic [DATA_WIDTH-1:0]   hold_q;
  logic [DATA_WIDTH-1:0]   wrdata_q;
  logic [ADDR_WIDTH-1:0]   address_q;
  logic                    wren_q;
  logic                    rden_q;
  logic [7:0]              tx_data_q;
  logic                    tx_valid_q;
  logic                    busy_q;
  logic                    frame_err_q;
  logic                    timeout_hit;
  logic                    addr_bad;

  assign addr_bad = |(rx_data & ADDR_MASK);

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_q;
  logic             collecting;

  assign collecting  = (state_q == WR_ADDR) || (state_q == WR_DLO) ||
                       (state_q == WR_DHI)  || (state_q == RD_ADDR);
  assign timeout_hit = collecting && !rx_valid && (to_cnt_q == CNT_LAST);

  // Inter-byte gap counter: runs only while collecting, restarts on each byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (!collecting || rx_valid || timeout_hit) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame FSM with registered RegFile, transmit and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      dlo_q       <= '0;
      hold_q      <= '0;
      wrdata_q    <= '0;
      address_q   <= '0;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      frame_err_q <= 1'b0;
      if (timeout_hit) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_valid && rx_data == HDR_WR) state_q <= WR_ADDR;
            else if (rx_valid && rx_data == HDR_RD) state_q <= RD_ADDR;
          end
          WR_ADDR: begin
            if (rx_valid) begin
              if (addr_bad) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
              end else begin
                addr_q  <= rx_data[ADDR_WIDTH-1:0];
                state_q <= WR_DLO;
              end
            end
          end
          WR_DLO: begin
            if (rx_valid) begin
              dlo_q   <= rx_data;
              state_q <= WR_DHI;
            end
          end
          WR_DHI: begin
            if (rx_valid) begin
              wrdata_q  <= {rx_data, dlo_q};
              address_q <= addr_q;
              wren_q    <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= WR_EXEC;
            end
          end
          WR_EXEC: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          RD_ADDR: begin
            if (rx_valid) begin
              if (addr_bad) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
              end else begin
                address_q <= rx_data[ADDR_WIDTH-1:0];
                rden_q    <= 1'b1;
                busy_q    <= 1'b1;
                state_q   <= RD_EXEC;
              end
            end
          end
          RD_EXEC: state_q <= RD_WAIT;
          RD_WAIT: begin
            // RegFile data is valid here, one cycle after RdEn.
            hold_q     <= RdData;
            tx_data_q  <= RdData[7:0];
            tx_valid_q <= 1'b1;
            state_q    <= TX_LO;
          end
          TX_LO: begin
            if (tx_ready) begin
              tx_data_q <= hold_q[15:8];
              state_q   <= TX_HI;
            end
          end
          TX_HI: begin
            if (tx_ready) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end
          end
          default: begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        endcase
      end
    end
  end

  assign WrData    = wrdata_q;
  assign address   = address_q;
  assign WrEn      = wren_q;
  assign RdEn      = rden_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/regfile_cmd_ctrl.md
# regfile_cmd_ctrl

Command-frame controller sitting directly upstream of the RegFile. It consumes an 8-bit byte stream from the serial receiver and decodes write-register and read-register frames. It drives the RegFile write/read port, then returns read data as two bytes to the serial transmitter over a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 16, RegFile word width; fixed at 16 because read data is returned as exactly two bytes.
- `ADDR_WIDTH`, 3, RegFile address width.
- `TIMEOUT_CYCLES`, 1024, maximum inter-byte gap inside a frame; used only when `CMD_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `WrData`  out  DATA_WIDTH  write data to RegFile.
- `address`  out  ADDR_WIDTH  RegFile address.
- `WrEn`  out  1  RegFile write enable, one-cycle pulse.
- `RdEn`  out  1  RegFile read enable, one-cycle pulse.
- `RdData`  in  DATA_WIDTH  RegFile read data, valid the cycle after `RdEn`.
- `tx_data`  out  8  byte to transmitter.
- `tx_valid`  out  1  `tx_data` valid; held until accepted.
- `tx_ready`  in  1  transmitter accepts the byte when `tx_valid && tx_ready`.
- `busy`  out  1  high in any state other than IDLE or a header/payload-collect state.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- Write frame: `0xAA`, addr, data_lo, data_hi. Read frame: `0xBB`, addr.
- In IDLE, any byte other than `0xAA` or `0xBB` is silently discarded, with no `frame_err`.
- Addr byte bits [7:ADDR_WIDTH] must be zero. Otherwise the frame is aborted: pulse `frame_err` and return to IDLE.
- States and transitions:
  - IDLE → WR_ADDR on `0xAA`; IDLE → RD_ADDR on `0xBB`.
  - WR_ADDR → WR_DLO → WR_DHI → WR_EXEC → IDLE.
  - RD_ADDR → RD_EXEC → RD_WAIT → TX_LO → TX_HI → IDLE.
- Collect states advance only on `rx_valid`.
- WR_EXEC: `WrEn`=1 for exactly one cycle, with `address` and `WrData` = {data_hi, data_lo} stable.
- RD_EXEC: `RdEn`=1 for one cycle. RD_WAIT: capture `RdData` into an internal 16-bit holding register.
- TX_LO / TX_HI: present captured [7:0] then [15:8] on `tx_data` with `tx_valid`=1. Advance on `tx_valid && tx_ready`.
- `rx_valid` in WR_EXEC, RD_EXEC, RD_WAIT, TX_LO or TX_HI: the byte is dropped; no error, no state change.
- `WrEn` and `RdEn` are never high in the same cycle.
- `address` and `WrData` hold their last value outside execute cycles.

## Timing
- Reset values: `WrData`=0, `address`=0, `WrEn`=0, `RdEn`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `frame_err`=0; state=IDLE; holding register=0.
- `rst` mid-frame or mid-transmit: immediate return to IDLE and all outputs to reset values. A partially sent byte pair is abandoned.
- Write latency: `WrEn` asserts on the cycle after the data_hi `rx_valid`.
- Read latency:
  - `RdEn` asserts on the cycle after the addr `rx_valid`.
  - `RdData` is sampled one cycle later.
  - `tx_valid` rises the cycle after sampling, so the first tx byte appears 3 cycles after the addr strobe.
- With `tx_ready` tied high, TX_LO and TX_HI last one cycle each.
- Back-to-back frames: a header byte arriving the cycle after a return to IDLE is accepted. The earliest next header is one cycle after WR_EXEC, or after the TX_HI handshake.
- `frame_err` pulses in the cycle after the offending strobe, together with entry to IDLE.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - A counter runs in WR_ADDR, WR_DLO, WR_DHI and RD_ADDR, cleared on each `rx_valid`.
  - When it reaches `TIMEOUT_CYCLES` with no byte: pulse `frame_err` and go to IDLE.
  - The counter never runs in IDLE, execute or TX states.
- Not defined: no counter logic; collect states wait indefinitely.

## Test plan
- Reset, then bytes AA,05,55,AE → one-cycle `WrEn` with `address`=5, `WrData`=16'hAE55; `frame_err` stays 0.
- After the write above, bytes BB,05 with `tx_ready`=1 → `RdEn` pulse, address=5; `tx_data` 55 then AE on consecutive `tx_valid` cycles; `busy` then low.
- Read with `tx_ready` held low for 5 cycles → `tx_valid`=1 with `tx_data`=55 stable throughout; no advance until `tx_ready` rises.
- Bytes 3C, then BB,09 → 3C ignored; addr 09 has an upper bit set → `frame_err` pulse, no `RdEn`, state IDLE.
- Bytes AA,02,11 then `rst` pulse, then BB,02 → no `WrEn` ever issued; read returns 00,00 (RegFile also reset).
- With `CMD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: AA,03 then 20 idle cycles → `frame_err` at cycle 16; a subsequent AA,03,01,00 writes 16'h0001 to location 3.
